// File: rtl/nios_system_pio_edge_if.sv
// Avalon-MM slave port bundle for the edge-capturing PIO.
// The interconnect drives master; the PIO takes slave.
interface nios_system_pio_edge_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output read_n,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  read_n,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_system_pio_edge.sv
// Avalon-MM parallel I/O: output register with set/clear,
// synchronised inputs, per-bit edge capture and masked irq.
module nios_system_pio_edge #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int              EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  nios_system_pio_edge_if.slave bus,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_OUTREAD = 3'd1;
  localparam logic [2:0] A_IRQMASK = 3'd2;
  localparam logic [2:0] A_EDGECAP = 3'd3;
  localparam logic [2:0] A_OUTSET  = 3'd4;
  localparam logic [2:0] A_OUTCLR  = 3'd5;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rsel;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       arm_q, arm_d;
  logic             armed;
  logic             irq_q, irq_d;
  logic             wr_stb, rd_stb;

  assign wr_stb = bus.chipselect & ~bus.write_n;
  assign rd_stb = bus.chipselect & ~bus.read_n;
  assign wd     = bus.writedata[WIDTH-1:0];

  // Writedata bits above WIDTH are architecturally ignored.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, bus.writedata};

  // Input synchroniser plus history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Edge polarity is fixed at elaboration.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = s2_q & ~s3_q;
      1:       edge_det = ~s2_q & s3_q;
      default: edge_det = s2_q ^ s3_q;
    endcase
  end

  // Capture stays disarmed until the sync chain has refilled
  // after reset, so stale reset zeros never look like edges.
  assign armed = (arm_q == 2'd3);
  assign arm_d = armed ? arm_q : arm_q + 2'd1;

  // Register writes: data/set/clear, mask, edge clear.
  always_comb begin
    out_d    = out_q;
    mask_d   = mask_q;
    clr_mask = '0;
    if (wr_stb) begin
      case (bus.address)
        A_DATA:    out_d    = wd;
        A_IRQMASK: mask_d   = wd;
        A_EDGECAP: clr_mask = wd;
        A_OUTSET:  out_d    = out_q | wd;
        A_OUTCLR:  out_d    = out_q & ~wd;
        default:   ;
      endcase
    end
  end

  // A fresh edge overrides a same-cycle clear so none is lost.
  always_comb begin
    cap_d = cap_q & ~clr_mask;
    if (armed) cap_d = cap_d | edge_det;
    irq_d = |(cap_d & mask_d);
  end

  // Read mux samples pre-write register values.
  always_comb begin
    rsel = '0;
    unique case (1'b1)
      bus.address == A_DATA:    rsel = s2_q;
      bus.address == A_OUTREAD: rsel = out_q;
      bus.address == A_IRQMASK: rsel = mask_q;
      bus.address == A_EDGECAP: rsel = cap_q;
      bus.address[2]:           rsel = '0;
    endcase
    rdata_d = rd_stb ? 32'(rsel) : rdata_q;
  end

  // Architectural state, read data and registered irq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= RESET_VALUE;
      mask_q  <= '0;
      cap_q   <= '0;
      arm_q   <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      arm_q   <= arm_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign out_port     = out_q;
  assign irq          = irq_q;
  assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_nios_system_pio_edge.sv
// Scoreboard bench for nios_system_pio_edge: an 8-bit rising
// instance and a 32-bit any-edge instance.
module tb_nios_system_pio_edge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in8 = 8'h02;
  logic [7:0]  out8;
  logic        irq8;
  logic [31:0] in32 = '0;
  logic [31:0] out32;
  logic        irq32;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] q8v[$];
  string       q8n[$];
  logic [31:0] q32v[$];
  string       q32n[$];
  logic        seen8 = 1'b0;
  logic        seen32 = 1'b0;

  nios_system_pio_edge_if bus8();
  nios_system_pio_edge_if bus32();

  nios_system_pio_edge #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0)
  ) dut8 (
    .clk(clk), .reset(reset), .bus(bus8),
    .in_port(in8), .out_port(out8), .irq(irq8)
  );

  nios_system_pio_edge #(
    .WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(2)
  ) dut32 (
    .clk(clk), .reset(reset), .bus(bus32),
    .in_port(in32), .out_port(out32), .irq(irq32)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitors: a read sampled on an edge is compared at the
  // following negedge against the oldest expected value.
  always @(posedge clk) begin
    seen8  <= bus8.chipselect & ~bus8.read_n;
    seen32 <= bus32.chipselect & ~bus32.read_n;
  end

  always @(negedge clk) begin
    if (seen8) begin
      if (q8v.size() == 0) begin
        total_cnt++;
        $display("FAIL rd8: unexpected read, got %h", bus8.readdata);
      end else begin
        chk(q8n.pop_front(), bus8.readdata, q8v.pop_front());
      end
    end
    if (seen32) begin
      if (q32v.size() == 0) begin
        total_cnt++;
        $display("FAIL rd32: unexpected read, got %h", bus32.readdata);
      end else begin
        chk(q32n.pop_front(), bus32.readdata, q32v.pop_front());
      end
    end
  end

  task automatic bus_cycle(input bit big, input bit rd, input bit wr,
                           input logic [2:0] a, input logic [31:0] wd,
                           input logic [31:0] exp, input string nm);
    @(negedge clk);
    if (big) begin
      bus32.address    = a;
      bus32.writedata  = wd;
      bus32.chipselect = 1'b1;
      bus32.read_n     = ~rd;
      bus32.write_n    = ~wr;
      if (rd) begin q32v.push_back(exp); q32n.push_back(nm); end
    end else begin
      bus8.address    = a;
      bus8.writedata  = wd;
      bus8.chipselect = 1'b1;
      bus8.read_n     = ~rd;
      bus8.write_n    = ~wr;
      if (rd) begin q8v.push_back(exp); q8n.push_back(nm); end
    end
    @(posedge clk);
    #1;
    bus8.chipselect  = 1'b0;
    bus8.read_n      = 1'b1;
    bus8.write_n     = 1'b1;
    bus32.chipselect = 1'b0;
    bus32.read_n     = 1'b1;
    bus32.write_n    = 1'b1;
  endtask

  task automatic wr8(input logic [2:0] a, input logic [31:0] wd);
    bus_cycle(1'b0, 1'b0, 1'b1, a, wd, '0, "");
  endtask

  task automatic rd8(input logic [2:0] a, input logic [31:0] exp,
                     input string nm);
    bus_cycle(1'b0, 1'b1, 1'b0, a, '0, exp, nm);
  endtask

  task automatic wr32(input logic [2:0] a, input logic [31:0] wd);
    bus_cycle(1'b1, 1'b0, 1'b1, a, wd, '0, "");
  endtask

  task automatic rd32(input logic [2:0] a, input logic [31:0] exp,
                      input string nm);
    bus_cycle(1'b1, 1'b1, 1'b0, a, '0, exp, nm);
  endtask

  initial begin
    bus8.address = '0;  bus8.writedata = '0;
    bus8.chipselect = 1'b0; bus8.read_n = 1'b1; bus8.write_n = 1'b1;
    bus32.address = '0; bus32.writedata = '0;
    bus32.chipselect = 1'b0; bus32.read_n = 1'b1; bus32.write_n = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out8", {24'h0, out8}, 32'h0000_00A5);
    chk("rst_irq8", {31'h0, irq8}, 32'h0);
    chk("rst_rdata8", bus8.readdata, 32'h0);
    chk("rst_out32", out32, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // in8[1] was high through reset: release must not capture it
    rd8(3'd3, 32'h0, "warmup_cap");

    // Write, set, clear
    wr8(3'd0, 32'h3C);
    chk("out_write", {24'h0, out8}, 32'h3C);
    wr8(3'd4, 32'h81);
    chk("out_set", {24'h0, out8}, 32'hBD);
    wr8(3'd5, 32'h0C);
    chk("out_clr", {24'h0, out8}, 32'hB1);
    rd8(3'd1, 32'h0000_00B1, "outread");

    // Reserved and simultaneous read/write
    rd8(3'd6, 32'h0, "rsvd6");
    rd8(3'd4, 32'h0, "outset_rd");
    wr8(3'd7, 32'hFF);
    chk("rsvd7_wr", {24'h0, out8}, 32'hB1);
    bus_cycle(1'b0, 1'b1, 1'b1, 3'd0, 32'h55, 32'h02, "rdwr_data");
    chk("rdwr_out", {24'h0, out8}, 32'h55);

    // Rising-edge capture on bit 0; bit 1 falls, ignored
    wr8(3'd2, 32'h01);
    rd8(3'd2, 32'h01, "mask_rd");
    @(negedge clk);
    in8 = 8'h01;
    @(posedge clk);
    @(posedge clk);
    #1 chk("irq_before", {31'h0, irq8}, 32'h0);
    @(posedge clk);
    #1 chk("irq_rise", {31'h0, irq8}, 32'h1);
    rd8(3'd3, 32'h01, "cap_rise");

    // Clear in the same cycle a new edge is captured
    @(negedge clk);
    in8 = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    in8 = 8'h01;
    @(posedge clk);
    @(posedge clk);
    wr8(3'd3, 32'h01);
    chk("clr_vs_edge_irq", {31'h0, irq8}, 32'h1);
    rd8(3'd3, 32'h01, "clr_vs_edge_cap");

    // Asynchronous reset mid-run
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out8", {24'h0, out8}, 32'h0000_00A5);
    chk("mid_rst_irq8", {31'h0, irq8}, 32'h0);
    chk("mid_rst_rdata", bus8.readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    rd8(3'd2, 32'h0, "mid_rst_mask");
    rd8(3'd3, 32'h0, "mid_rst_cap");

    // Plain clear drops irq on the next edge
    wr8(3'd2, 32'h01);
    @(negedge clk);
    in8 = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    in8 = 8'h01;
    repeat (4) @(posedge clk);
    #1 chk("irq_again", {31'h0, irq8}, 32'h1);
    wr8(3'd3, 32'h01);
    chk("irq_cleared", {31'h0, irq8}, 32'h0);
    rd8(3'd3, 32'h0, "cap_cleared");

    // 32-bit any-edge instance
    @(negedge clk);
    in32 = 32'hFFFF_0000;
    repeat (4) @(posedge clk);
    rd32(3'd3, 32'hFFFF_0000, "cap32_rise");
    rd32(3'd0, 32'hFFFF_0000, "data32");
    wr32(3'd2, 32'h0001_0000);
    chk("irq32_mask", {31'h0, irq32}, 32'h1);
    wr32(3'd2, 32'h0);
    chk("irq32_nomask", {31'h0, irq32}, 32'h0);
    wr32(3'd3, 32'hFFFF_FFFF);
    rd32(3'd3, 32'h0, "cap32_clr");
    @(negedge clk);
    in32 = 32'h0;
    repeat (4) @(posedge clk);
    rd32(3'd3, 32'hFFFF_0000, "cap32_fall");
    wr32(3'd0, 32'hDEAD_BEEF);
    rd32(3'd1, 32'hDEAD_BEEF, "out32_rd");

    repeat (3) @(posedge clk);
    #1;
    chk("q8_drained", 32'(q8v.size()), 32'h0);
    chk("q32_drained", 32'(q32v.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
